// File: rtl/timer_key_controller.sv
// Front-panel sequencer for the count-down timer.
// Turns four raw button levels and the timer's ring flag into an
// edit/run/pause/alarm state machine. It holds the BCD preset and issues
// fixed-width set/play/stop/reset command pulses to the timer.
module timer_key_controller #(
   parameter int CLK_HZ    = 5_000_000,  // clock cycles per second
   parameter int RING_SEC  = 10,         // seconds the alarm rings before auto-silence
   parameter int PULSE_CYC = 2           // command pulse width in cycles, 1..15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_mode,
   input  logic       key_up,
   input  logic       key_start,
   input  logic       key_clr,
   input  logic       timer_ring,
   input  logic       timer_counting,
   output logic [7:0] hour_bcd_out,
   output logic [7:0] minute_bcd_out,
   output logic [7:0] second_bcd_out,
   output logic       set_out,
   output logic       play_out,
   output logic       stop_out,
   output logic       reset_out,
   output logic       alarm_on,
   output logic       blink,
   output logic [2:0] state_code
);

   localparam int TICK_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int SEC_W     = (RING_SEC > 0) ? $clog2(RING_SEC + 1) : 1;
   localparam int BLINK_CYC = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
   localparam int BLINK_W   = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
   localparam logic [3:0] PULSE_W = 4'(PULSE_CYC);

   // Bit positions inside the synchroniser / event vectors.
   localparam int K_MODE  = 0;
   localparam int K_UP    = 1;
   localparam int K_START = 2;
   localparam int K_CLR   = 3;
   localparam int K_RING  = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EDIT_H = 3'd1,
      ST_EDIT_M = 3'd2,
      ST_EDIT_S = 3'd3,
      ST_LOAD   = 3'd4,
      ST_RUN    = 3'd5,
      ST_PAUSED = 3'd6,
      ST_ALARM  = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_SET   = 3'd1,
      CMD_PLAY  = 3'd2,
      CMD_STOP  = 3'd3,
      CMD_RESET = 3'd4
   } cmd_t;

   // BCD increment with carry from the low digit and wrap at lim back to 00.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
      if (v == lim)
         return 8'h00;
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return v + 8'd1;
   endfunction

   logic [4:0] raw_in;
   logic [4:0] sync1_q, sync2_q, prev_q, evt_q;

   state_t     state_q, state_d;
   logic [7:0] hour_q, hour_d, minute_q, minute_d, second_q, second_d;
   logic [3:0] cnt_q, cnt_d;
   cmd_t       cmd_q, cmd_d, launch;

   logic [TICK_W-1:0]  tick_q;
   logic [SEC_W-1:0]   sec_q;
   logic [BLINK_W-1:0] blink_cnt_q;
   logic               blink_q;

   logic       busy, in_edit, timeout, preset_zero, any_key;
   logic       ev_clr, ev_start, ev_mode, ev_up, ev_ring;
   logic [3:0] key_ev;
   logic       unused_counting;

   // The counting flag is status only; it deliberately drives nothing.
   assign unused_counting = timer_counting;

   assign raw_in = {timer_ring, key_clr, key_start, key_up, key_mode};

   // Two-flop synchroniser followed by a registered rising-edge detector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         evt_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         evt_q   <= sync2_q & ~prev_q;
      end
   end

   assign busy        = (cnt_q != 4'd0);
   assign in_edit     = (state_q == ST_EDIT_H) || (state_q == ST_EDIT_M) || (state_q == ST_EDIT_S);
   assign timeout     = (sec_q == SEC_W'(RING_SEC));
   assign preset_zero = (hour_q == 8'h00) && (minute_q == 8'h00) && (second_q == 8'h00);

   // Key events are dropped while a pulse is in flight; priority clr > start > mode > up.
   assign key_ev   = evt_q[3:0] & {4{~busy}};
   assign any_key  = |key_ev;
   assign ev_clr   = key_ev[K_CLR];
   assign ev_start = key_ev[K_START] & ~key_ev[K_CLR];
   assign ev_mode  = key_ev[K_MODE]  & ~key_ev[K_CLR] & ~key_ev[K_START];
   assign ev_up    = key_ev[K_UP]    & ~key_ev[K_CLR] & ~key_ev[K_START] & ~key_ev[K_MODE];
   assign ev_ring  = evt_q[K_RING];

   // Next state, preset edits and command-pulse launch.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
      state_d  = state_q;
      hour_d   = hour_q;
      minute_d = minute_q;
      second_d = second_q;
      cnt_d    = busy ? (cnt_q - 4'd1) : 4'd0;
      cmd_d    = cmd_q;
      launch   = CMD_NONE;

      case (state_q)
         ST_IDLE: begin
            if (ev_clr) begin
               launch = CMD_RESET;
            end else if (ev_start) begin
               if (!preset_zero) begin
                  launch  = CMD_PLAY;
                  state_d = ST_RUN;
               end
            end else if (ev_mode) begin
               state_d = ST_EDIT_H;
            end
         end

         ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
            if (ev_clr) begin
               hour_d   = 8'h00;
               minute_d = 8'h00;
               second_d = 8'h00;
               state_d  = ST_IDLE;
            end else if (ev_mode) begin
               case (state_q)
                  ST_EDIT_H: state_d = ST_EDIT_M;
                  ST_EDIT_M: state_d = ST_EDIT_S;
                  default:   state_d = ST_LOAD;
               endcase
            end else if (ev_up) begin
               case (state_q)
                  ST_EDIT_H: hour_d   = bcd_inc(hour_q, 8'h23);
                  ST_EDIT_M: minute_d = bcd_inc(minute_q, 8'h59);
                  default:   second_d = bcd_inc(second_q, 8'h59);
               endcase
            end
         end

         ST_LOAD: begin
            // One launch cycle, then hold here until the last pulse cycle.
            if (!busy)
               launch = CMD_SET;
            else if (cnt_q == 4'd1)
               state_d = ST_IDLE;
         end

         ST_RUN: begin
            if (ev_ring) begin
               state_d = ST_ALARM;
            end else if (ev_clr) begin
               launch  = CMD_RESET;
               state_d = ST_IDLE;
            end else if (ev_start) begin
               launch  = CMD_STOP;
               state_d = ST_PAUSED;
            end
         end

         ST_PAUSED: begin
            if (ev_clr) begin
               launch  = CMD_RESET;
               state_d = ST_IDLE;
            end else if (ev_start) begin
               launch  = CMD_PLAY;
               state_d = ST_RUN;
            end else if (ev_mode) begin
               state_d = ST_EDIT_H;
            end
         end

         ST_ALARM: begin
            // A key on the timeout cycle still yields only the one reset pulse.
            if ((any_key || timeout) && !busy) begin
               launch  = CMD_RESET;
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (launch != CMD_NONE) begin
         cnt_d = PULSE_W;
         cmd_d = launch;
      end
   end

   // State, preset and pulse-engine registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         hour_q   <= 8'h00;
         minute_q <= 8'h00;
         second_q <= 8'h00;
         cnt_q    <= 4'd0;
         cmd_q    <= CMD_NONE;
      end else begin
         state_q  <= state_d;
         hour_q   <= hour_d;
         minute_q <= minute_d;
         second_q <= second_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
      end
   end

   // Alarm duration: sub-second tick plus saturating whole-second count, live only in ALARM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q <= '0;
         sec_q  <= '0;
      end else if (state_q != ST_ALARM) begin
         tick_q <= '0;
         sec_q  <= '0;
      end else if (tick_q == TICK_W'(CLK_HZ - 1)) begin
         tick_q <= '0;
         if (!timeout)
            sec_q <= sec_q + SEC_W'(1);
      end else begin
         tick_q <= tick_q + TICK_W'(1);
      end
   end

   // Blink generator: toggles every quarter second while editing, parked high otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b1;
      end else if (!in_edit) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b1;
      end else if (blink_cnt_q == BLINK_W'(BLINK_CYC - 1)) begin
         blink_cnt_q <= '0;
         blink_q     <= ~blink_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
   end

   assign hour_bcd_out   = hour_q;
   assign minute_bcd_out = minute_q;
   assign second_bcd_out = second_q;

   assign set_out   = busy && (cmd_q == CMD_SET);
   assign play_out  = busy && (cmd_q == CMD_PLAY);
   assign stop_out  = busy && (cmd_q == CMD_STOP);
   assign reset_out = busy && (cmd_q == CMD_RESET);

   assign alarm_on   = (state_q == ST_ALARM);
   assign blink      = in_edit ? blink_q : 1'b1;
   assign state_code = state_q;

endmodule

// File: tb/tb_timer_key_controller.sv
// Self-checking bench for timer_key_controller with a small integer model
// of the front-panel rules and a pulse monitor that counts command pulses.
module tb_timer_key_controller;

   localparam int CLK_HZ    = 20;
   localparam int RING_SEC  = 2;
   localparam int PULSE_CYC = 2;

   // Key indices and model state numbers.
   localparam int K_MODE = 0, K_UP = 1, K_START = 2, K_CLR = 3;
   localparam int S_IDLE = 0, S_EH = 1, S_EM = 2, S_ES = 3, S_RUN = 5, S_PAUSED = 6, S_ALARM = 7;

   logic       clk, rst_n;
   logic [3:0] keys;
   logic       timer_ring, timer_counting;
   logic [7:0] hour_bcd_out, minute_bcd_out, second_bcd_out;
   logic       set_out, play_out, stop_out, reset_out, alarm_on, blink;
   logic [2:0] state_code;

   timer_key_controller #(
      .CLK_HZ   (CLK_HZ),
      .RING_SEC (RING_SEC),
      .PULSE_CYC(PULSE_CYC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_mode      (keys[K_MODE]),
      .key_up        (keys[K_UP]),
      .key_start     (keys[K_START]),
      .key_clr       (keys[K_CLR]),
      .timer_ring    (timer_ring),
      .timer_counting(timer_counting),
      .hour_bcd_out  (hour_bcd_out),
      .minute_bcd_out(minute_bcd_out),
      .second_bcd_out(second_bcd_out),
      .set_out       (set_out),
      .play_out      (play_out),
      .stop_out      (stop_out),
      .reset_out     (reset_out),
      .alarm_on      (alarm_on),
      .blink         (blink),
      .state_code    (state_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Pulse monitor: index 0 set, 1 play, 2 stop, 3 reset.
   int p_cnt[4] = '{0, 0, 0, 0};
   int p_w[4]   = '{0, 0, 0, 0};
   int p_run[4] = '{0, 0, 0, 0};
   logic [3:0] pv;
   assign pv = {reset_out, stop_out, play_out, set_out};

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (pv[i]) begin
            p_run[i]++;
         end else if (p_run[i] > 0) begin
            p_cnt[i]++;
            p_w[i]   = p_run[i];
            p_run[i] = 0;
         end
      end
   end

   // Behavioural model: preset as plain integers, pulses as expected counts.
   int m_state = S_IDLE;
   int m_h = 0, m_m = 0, m_s = 0;
   int exp_cnt[4] = '{0, 0, 0, 0};

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) + (v % 10));
   endfunction

   function automatic logic [23:0] exp_preset();
      return {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)};
   endfunction

   logic [23:0] got_preset;
   assign got_preset = {hour_bcd_out, minute_bcd_out, second_bcd_out};

   task automatic model_key(input int k);
      case (m_state)
         S_IDLE: begin
            if (k == K_CLR) exp_cnt[3]++;
            else if (k == K_START) begin
               if (m_h + m_m + m_s > 0) begin
                  exp_cnt[1]++;
                  m_state = S_RUN;
               end
            end else if (k == K_MODE) m_state = S_EH;
         end
         S_EH, S_EM, S_ES: begin
            if (k == K_CLR) begin
               m_h = 0; m_m = 0; m_s = 0;
               m_state = S_IDLE;
            end else if (k == K_MODE) begin
               if (m_state == S_ES) begin
                  exp_cnt[0]++;
                  m_state = S_IDLE;
               end else m_state = m_state + 1;
            end else if (k == K_UP) begin
               if (m_state == S_EH) m_h = (m_h + 1) % 24;
               else if (m_state == S_EM) m_m = (m_m + 1) % 60;
               else m_s = (m_s + 1) % 60;
            end
         end
         S_RUN: begin
            if (k == K_CLR) begin
               exp_cnt[3]++;
               m_state = S_IDLE;
            end else if (k == K_START) begin
               exp_cnt[2]++;
               m_state = S_PAUSED;
            end
         end
         S_PAUSED: begin
            if (k == K_CLR) begin
               exp_cnt[3]++;
               m_state = S_IDLE;
            end else if (k == K_START) begin
               exp_cnt[1]++;
               m_state = S_RUN;
            end else if (k == K_MODE) m_state = S_EH;
         end
         S_ALARM: begin
            exp_cnt[3]++;
            m_state = S_IDLE;
         end
         default: m_state = S_IDLE;
      endcase
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // One key press: 5 cycles high, 5 low; model updated alongside.
   task automatic press(input int k);
      keys[k] = 1'b1;
      timer_counting = 1'($urandom_range(0, 1));
      wait_cyc(5);
      keys[k] = 1'b0;
      wait_cyc(5);
      model_key(k);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      keys = '0;
      timer_ring = 1'b0;
      timer_counting = 1'b0;
      wait_cyc(3);
      total_cnt++;
      if (state_code !== 3'd0) $display("FAIL reset_state got %0d exp 0", state_code);
      else pass_cnt++;
      total_cnt++;
      if (got_preset !== 24'h000000) $display("FAIL reset_preset got %h exp 000000", got_preset);
      else pass_cnt++;
      total_cnt++;
      if (pv !== 4'b0000) $display("FAIL reset_pulses got %b exp 0000", pv);
      else pass_cnt++;
      total_cnt++;
      if (blink !== 1'b1) $display("FAIL reset_blink got %b exp 1", blink);
      else pass_cnt++;
      total_cnt++;
      if (alarm_on !== 1'b0) $display("FAIL reset_alarm got %b exp 0", alarm_on);
      else pass_cnt++;
      rst_n = 1'b1;
      wait_cyc(3);
   endtask

   task automatic test_blink;
      int toggles = 0;
      logic last;
      press(K_MODE);
      last = blink;
      for (int i = 0; i < 30; i++) begin
         wait_cyc(1);
         if (blink !== last) toggles++;
         last = blink;
      end
      total_cnt++;
      if (toggles < 5 || toggles > 7) $display("FAIL blink_edit toggles got %0d exp 5..7", toggles);
      else pass_cnt++;
      press(K_CLR);
      wait_cyc(1);
      total_cnt++;
      if (blink !== 1'b1 || state_code !== 3'(m_state))
         $display("FAIL blink_idle got blink=%b state=%0d exp blink=1 state=%0d", blink, state_code, m_state);
      else pass_cnt++;
   endtask

   task automatic test_edit_wrap;
      press(K_MODE);
      repeat (23) press(K_UP);
      press(K_MODE);
      repeat (59) press(K_UP);
      press(K_MODE);
      repeat (9) press(K_UP);
      total_cnt++;
      if (got_preset !== 24'h235909) $display("FAIL edit_235909 got %h exp 235909", got_preset);
      else pass_cnt++;
      press(K_MODE);
      total_cnt++;
      if (p_cnt[0] !== exp_cnt[0] || state_code !== 3'(m_state))
         $display("FAIL edit_load1 got set=%0d state=%0d exp set=%0d state=%0d", p_cnt[0], state_code, exp_cnt[0], m_state);
      else pass_cnt++;
      press(K_MODE); press(K_UP);
      press(K_MODE); press(K_UP);
      press(K_MODE); press(K_UP);
      total_cnt++;
      if (got_preset !== 24'h000010 || got_preset !== exp_preset())
         $display("FAIL edit_wrap got %h exp 000010 (model %h)", got_preset, exp_preset());
      else pass_cnt++;
      press(K_MODE);
      total_cnt++;
      if (p_w[0] !== PULSE_CYC || p_cnt[0] !== exp_cnt[0])
         $display("FAIL edit_set_pulse got width=%0d count=%0d exp width=%0d count=%0d", p_w[0], p_cnt[0], PULSE_CYC, exp_cnt[0]);
      else pass_cnt++;
      total_cnt++;
      if (state_code !== 3'd0 || got_preset !== 24'h000010)
         $display("FAIL edit_after_load got state=%0d preset=%h exp state=0 preset=000010", state_code, got_preset);
      else pass_cnt++;
   endtask

   task automatic test_start_idle;
      press(K_START);
      total_cnt++;
      if (p_w[1] !== PULSE_CYC || p_cnt[1] !== exp_cnt[1] || state_code !== 3'd5)
         $display("FAIL start_play got width=%0d count=%0d state=%0d exp width=%0d count=%0d state=5", p_w[1], p_cnt[1], state_code, PULSE_CYC, exp_cnt[1]);
      else pass_cnt++;
   endtask

   task automatic test_pause_resume;
      press(K_START);
      total_cnt++;
      if (p_w[2] !== PULSE_CYC || p_cnt[2] !== exp_cnt[2] || state_code !== 3'd6)
         $display("FAIL pause_stop got width=%0d count=%0d state=%0d exp width=%0d count=%0d state=6", p_w[2], p_cnt[2], state_code, PULSE_CYC, exp_cnt[2]);
      else pass_cnt++;
      press(K_START);
      total_cnt++;
      if (p_cnt[1] !== exp_cnt[1] || state_code !== 3'd5)
         $display("FAIL resume_play got count=%0d state=%0d exp count=%0d state=5", p_cnt[1], state_code, exp_cnt[1]);
      else pass_cnt++;
      press(K_CLR);
      total_cnt++;
      if (p_cnt[3] !== exp_cnt[3] || state_code !== 3'd0)
         $display("FAIL run_clr got reset=%0d state=%0d exp reset=%0d state=0", p_cnt[3], state_code, exp_cnt[3]);
      else pass_cnt++;
      // Zero the preset, then start must do nothing.
      press(K_MODE);
      press(K_CLR);
      press(K_START);
      total_cnt++;
      if (p_cnt[1] !== exp_cnt[1] || state_code !== 3'd0 || got_preset !== 24'h000000)
         $display("FAIL start_zero got play=%0d state=%0d preset=%h exp play=%0d state=0 preset=000000", p_cnt[1], state_code, got_preset, exp_cnt[1]);
      else pass_cnt++;
   endtask

   task automatic enter_run;
      press(K_MODE); press(K_UP); press(K_MODE); press(K_MODE); press(K_MODE);
      press(K_START);
   endtask

   task automatic test_alarm_timeout;
      int base, elapsed;
      enter_run();
      total_cnt++;
      if (state_code !== 3'd5) $display("FAIL alarm_pre_run got state=%0d exp 5", state_code);
      else pass_cnt++;
      base = p_cnt[3];
      timer_ring = 1'b1;
      if (m_state == S_RUN) m_state = S_ALARM;
      wait_cyc(6);
      total_cnt++;
      if (state_code !== 3'd7 || alarm_on !== 1'b1)
         $display("FAIL alarm_enter got state=%0d alarm=%b exp state=7 alarm=1", state_code, alarm_on);
      else pass_cnt++;
      elapsed = 6;
      while (p_cnt[3] == base && elapsed < 120) begin
         wait_cyc(1);
         elapsed++;
      end
      exp_cnt[3]++;
      m_state = S_IDLE;
      total_cnt++;
      if (elapsed < 44 || elapsed > 50)
         $display("FAIL alarm_timeout got %0d cycles exp 44..50", elapsed);
      else pass_cnt++;
      wait_cyc(5);
      total_cnt++;
      if (p_cnt[3] !== exp_cnt[3] || state_code !== 3'd0 || alarm_on !== 1'b0)
         $display("FAIL alarm_silenced got reset=%0d state=%0d alarm=%b exp reset=%0d state=0 alarm=0", p_cnt[3], state_code, alarm_on, exp_cnt[3]);
      else pass_cnt++;
      timer_ring = 1'b0;
      wait_cyc(5);
   endtask

   task automatic test_alarm_key;
      press(K_START);
      timer_ring = 1'b1;
      if (m_state == S_RUN) m_state = S_ALARM;
      wait_cyc(10);
      total_cnt++;
      if (state_code !== 3'd7) $display("FAIL alarm2_enter got state=%0d exp 7", state_code);
      else pass_cnt++;
      press(K_UP);
      total_cnt++;
      if (p_cnt[3] !== exp_cnt[3] || state_code !== 3'd0)
         $display("FAIL alarm_key got reset=%0d state=%0d exp reset=%0d state=0", p_cnt[3], state_code, exp_cnt[3]);
      else pass_cnt++;
      wait_cyc(50);
      total_cnt++;
      if (p_cnt[3] !== exp_cnt[3] || state_code !== 3'd0)
         $display("FAIL alarm_single got reset=%0d state=%0d exp reset=%0d state=0", p_cnt[3], state_code, exp_cnt[3]);
      else pass_cnt++;
      timer_ring = 1'b0;
      wait_cyc(5);
   endtask

   task automatic test_collisions;
      press(K_START);
      press(K_START);
      total_cnt++;
      if (state_code !== 3'd6) $display("FAIL coll_paused got state=%0d exp 6", state_code);
      else pass_cnt++;
      keys[K_CLR] = 1'b1;
      keys[K_START] = 1'b1;
      wait_cyc(5);
      keys = '0;
      wait_cyc(5);
      model_key(K_CLR);
      total_cnt++;
      if (p_cnt !== exp_cnt || state_code !== 3'd0)
         $display("FAIL coll_clr_start got set=%0d play=%0d stop=%0d reset=%0d state=%0d exp %0d %0d %0d %0d state=0",
                  p_cnt[0], p_cnt[1], p_cnt[2], p_cnt[3], state_code, exp_cnt[0], exp_cnt[1], exp_cnt[2], exp_cnt[3]);
      else pass_cnt++;
      // clr arrives one cycle after start, landing while the play pulse is active.
      keys[K_START] = 1'b1;
      wait_cyc(1);
      keys[K_CLR] = 1'b1;
      wait_cyc(5);
      keys = '0;
      wait_cyc(5);
      model_key(K_START);
      total_cnt++;
      if (p_cnt !== exp_cnt || state_code !== 3'd5)
         $display("FAIL coll_during_pulse got set=%0d play=%0d stop=%0d reset=%0d state=%0d exp %0d %0d %0d %0d state=5",
                  p_cnt[0], p_cnt[1], p_cnt[2], p_cnt[3], state_code, exp_cnt[0], exp_cnt[1], exp_cnt[2], exp_cnt[3]);
      else pass_cnt++;
      press(K_CLR);
   endtask

   task automatic test_random;
      int k;
      for (int n = 0; n < 40; n++) begin
         k = int'($urandom_range(0, 3));
         press(k);
         total_cnt++;
         if (state_code !== 3'(m_state))
            $display("FAIL rand_state step %0d key %0d got %0d exp %0d", n, k, state_code, m_state);
         else pass_cnt++;
         total_cnt++;
         if (got_preset !== exp_preset())
            $display("FAIL rand_preset step %0d key %0d got %h exp %h", n, k, got_preset, exp_preset());
         else pass_cnt++;
         total_cnt++;
         if (p_cnt !== exp_cnt)
            $display("FAIL rand_pulses step %0d key %0d got %0d %0d %0d %0d exp %0d %0d %0d %0d", n, k,
                     p_cnt[0], p_cnt[1], p_cnt[2], p_cnt[3], exp_cnt[0], exp_cnt[1], exp_cnt[2], exp_cnt[3]);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_midpulse;
      int waited = 0;
      press(K_CLR);
      for (int r = 0; r < 2 && (m_h + m_m + m_s == 0); r++) begin
         press(K_MODE); press(K_UP); press(K_MODE); press(K_MODE); press(K_MODE);
      end
      keys[K_START] = 1'b1;
      while (play_out !== 1'b1 && waited < 20) begin
         wait_cyc(1);
         waited++;
      end
      total_cnt++;
      if (play_out !== 1'b1) $display("FAIL midpulse_play got %b exp 1 within 20 cycles", play_out);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (play_out !== 1'b0 || pv !== 4'b0000) $display("FAIL midpulse_drop got pulses=%b exp 0000", pv);
      else pass_cnt++;
      total_cnt++;
      if (state_code !== 3'd0 || got_preset !== 24'h000000 || blink !== 1'b1 || alarm_on !== 1'b0)
         $display("FAIL midpulse_regs got state=%0d preset=%h blink=%b alarm=%b exp 0 000000 1 0", state_code, got_preset, blink, alarm_on);
      else pass_cnt++;
      keys = '0;
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(2);
   endtask

   initial begin
      test_reset();
      test_blink();
      test_edit_wrap();
      test_start_idle();
      test_pause_resume();
      test_alarm_timeout();
      test_alarm_key();
      test_collisions();
      test_random();
      test_reset_midpulse();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
